sensor_raw_to_bcd: RTL and testbench

//  Downstream consumer of the I2C master's 16-bit data_out (MSB:LSB sensor word).

---
 rtl/sensor_raw_to_bcd.sv | 161 ++++++++++++++++
 tb/tb_sensor_raw_to_bcd.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/sensor_raw_to_bcd.sv
// Raw temperature/humidity sensor word to signed tenths in BCD.
// Shift-add multiply, offset and clamp, then double-dabble conversion.
module sensor_raw_to_bcd #(
    parameter int T_GAIN = 1757,
    parameter int T_OFFS = 469,
    parameter int H_GAIN = 1250,
    parameter int H_OFFS = 60,
    parameter int H_MAX  = 1000
) (
    input  logic        clk100MHz,
    input  logic        rst,
    input  logic        start,
    input  logic        mode,
    input  logic [15:0] raw_in,
    output logic        busy,
    output logic        done,
    output logic        neg,
    output logic [15:0] bcd
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_MULT,
        S_OFFS,
        S_BCD,
        S_DONE
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic               r_mode;
    logic [15:0]        r_raw;
    logic [26:0]        r_gain;
    logic [26:0]        r_acc;
    logic [4:0]         r_cnt;
    logic               r_neg_n;
    logic [15:0]        r_dd;
    logic [10:0]        r_sh;
    logic               r_busy;
    logic               r_done;
    logic               r_neg;
    logic [15:0]        r_bcd;

    logic               w_accept;
    logic [10:0]        w_scaled;
    logic [11:0]        w_offs;
    logic signed [11:0] w_v;
    logic signed [11:0] w_vneg;
    logic [10:0]        w_mag;
    logic               w_neg_n;
    logic [15:0]        w_adj;

    // The done cycle blocks acceptance so a held start restarts one cycle later.
    assign w_accept = start && !r_done;

    assign busy = r_busy;
    assign done = r_done;
    assign neg  = r_neg;
    assign bcd  = r_bcd;

    // Next-state logic for the conversion sequence.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: if (w_accept) w_next = S_MULT;
            S_MULT: if (r_cnt == 5'd15) w_next = S_OFFS;
            S_OFFS: w_next = S_BCD;
            S_BCD:  if (r_cnt == 5'd10) w_next = S_DONE;
            S_DONE: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Scale, subtract offset, then sign/magnitude or clamp by mode.
    always_comb begin
        w_scaled = r_acc[26:16];
        w_offs   = r_mode ? 12'(H_OFFS) : 12'(T_OFFS);
        w_v      = $signed({1'b0, w_scaled}) - $signed(w_offs);
        w_vneg   = -w_v;
        w_mag    = 11'd0;
        w_neg_n  = 1'b0;
        if (r_mode) begin
            if (w_v < 0)
                w_mag = 11'd0;
            else if (w_v > $signed(12'(H_MAX)))
                w_mag = 11'(H_MAX);
            else
                w_mag = w_v[10:0];
        end else begin
            w_neg_n = w_v[11];
            w_mag   = w_v[11] ? w_vneg[10:0] : w_v[10:0];
        end
    end

    // Double-dabble correction: add 3 to each digit of 5 or more.
    always_comb begin
        w_adj = r_dd;
        for (int i = 0; i < 4; i++) begin
            if (r_dd[4*i +: 4] >= 4'd5)
                w_adj[4*i +: 4] = r_dd[4*i +: 4] + 4'd3;
        end
    end

    // State register, datapath and registered outputs.
    always_ff @(posedge clk100MHz) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_mode  <= 1'b0;
            r_raw   <= '0;
            r_gain  <= '0;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_neg_n <= 1'b0;
            r_dd    <= '0;
            r_sh    <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_neg   <= 1'b0;
            r_bcd   <= '0;
        end else begin
            r_state <= w_next;
            r_busy  <= (r_state != S_IDLE) && (r_state != S_DONE);
            r_done  <= (r_state == S_DONE);
            unique case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_raw  <= raw_in;
                        r_mode <= mode;
                        r_gain <= mode ? 27'(H_GAIN) : 27'(T_GAIN);
                        r_acc  <= '0;
                        r_cnt  <= '0;
                    end
                end
                S_MULT: begin
                    if (r_raw[0])
                        r_acc <= r_acc + r_gain;
                    r_raw  <= {1'b0, r_raw[15:1]};
                    r_gain <= {r_gain[25:0], 1'b0};
                    r_cnt  <= r_cnt + 5'd1;
                end
                S_OFFS: begin
                    r_sh    <= w_mag;
                    r_neg_n <= w_neg_n;
                    r_dd    <= '0;
                    r_cnt   <= '0;
                end
                S_BCD: begin
                    r_dd  <= {w_adj[14:0], r_sh[10]};
                    r_sh  <= {r_sh[9:0], 1'b0};
                    r_cnt <= r_cnt + 5'd1;
                end
                S_DONE: begin
                    r_bcd <= r_dd;
                    r_neg <= r_neg_n;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sensor_raw_to_bcd.sv
// Self-checking bench for sensor_raw_to_bcd.
// Directed cases plus random words against an arithmetic reference.
module tb_sensor_raw_to_bcd;

    logic        clk100MHz = 1'b0;
    logic        rst;
    logic        start;
    logic        mode;
    logic [15:0] raw_in;
    logic        busy;
    logic        done;
    logic        neg;
    logic [15:0] bcd;

    int          n_chk = 0;
    int          n_err = 0;
    logic        last_neg = 1'b0;
    logic [15:0] last_bcd = 16'h0000;

    sensor_raw_to_bcd dut (
        .clk100MHz (clk100MHz),
        .rst       (rst),
        .start     (start),
        .mode      (mode),
        .raw_in    (raw_in),
        .busy      (busy),
        .done      (done),
        .neg       (neg),
        .bcd       (bcd)
    );

    always #5 clk100MHz = ~clk100MHz;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic void ref_conv(input logic m, input logic [15:0] r,
                                     output logic n, output logic [15:0] b);
        int gain, offs, scaled, v, mag;
        gain   = m ? 1250 : 1757;
        offs   = m ? 60 : 469;
        scaled = (gain * int'(r)) / 65536;
        v      = scaled - offs;
        if (m) begin
            n   = 1'b0;
            mag = (v < 0) ? 0 : ((v > 1000) ? 1000 : v);
        end else begin
            n   = (v < 0);
            mag = (v < 0) ? -v : v;
        end
        b = {4'(mag / 1000), 4'((mag / 100) % 10),
             4'((mag / 10) % 10), 4'(mag % 10)};
    endfunction

    task automatic run(input logic m, input logic [15:0] r,
                       input int glitch, input string tag);
        logic        en;
        logic [15:0] eb;
        int          k;
        ref_conv(m, r, en, eb);
        @(negedge clk100MHz);
        start  = 1'b1;
        mode   = m;
        raw_in = r;
        @(posedge clk100MHz);
        #1;
        start  = 1'b0;
        mode   = 1'($urandom);
        raw_in = 16'($urandom);
        for (k = 1; k <= 40; k++) begin
            @(posedge clk100MHz);
            #1;
            if (k == glitch) begin
                start  = 1'b1;
                raw_in = 16'h0000;
                mode   = 1'b0;
            end else begin
                start = 1'b0;
            end
            if (k == 1)
                check({tag, "_busy_on"}, 32'(busy), 32'd1);
            if (k == 10)
                check({tag, "_hold"}, {15'd0, neg, bcd}, {15'd0, last_neg, last_bcd});
            if (done)
                break;
        end
        start = 1'b0;
        check({tag, "_latency"}, k, 29);
        check({tag, "_busy_done"}, 32'(busy), 32'd0);
        check({tag, "_neg"}, 32'(neg), 32'(en));
        check({tag, "_bcd"}, 32'(bcd), 32'(eb));
        last_neg = en;
        last_bcd = eb;
        @(posedge clk100MHz);
        #1;
        check({tag, "_pulse"}, 32'(done), 32'd0);
    endtask

    initial begin
        int          first;
        int          second;
        int          ndone;
        logic        en;
        logic [15:0] eb;

        rst    = 1'b1;
        start  = 1'b0;
        mode   = 1'b0;
        raw_in = 16'h0000;
        repeat (3) @(posedge clk100MHz);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_neg", 32'(neg), 32'd0);
        check("rst_bcd", 32'(bcd), 32'd0);
        rst = 1'b0;

        run(1'b0, 16'h5D74, 0, "t1");
        check("t1_const", 32'(bcd), 32'h0172);
        run(1'b1, 16'h5D74, 0, "t2");
        check("t2_const", 32'(bcd), 32'h0396);
        run(1'b0, 16'h0000, 0, "t3_lo");
        check("t3_lo_const", {15'd0, neg, bcd}, {15'd0, 1'b1, 16'h0469});
        run(1'b0, 16'hFFFF, 0, "t3_hi");
        check("t3_hi_const", {15'd0, neg, bcd}, {15'd0, 1'b0, 16'h1287});
        run(1'b1, 16'h0000, 0, "t4_lo");
        check("t4_lo_const", {15'd0, neg, bcd}, 32'h0000);
        run(1'b1, 16'hFFFF, 0, "t4_hi");
        check("t4_hi_const", {15'd0, neg, bcd}, 32'h1000);
        run(1'b0, 16'h5D74, 5, "t5_glitch");
        check("t5_const", 32'(bcd), 32'h0172);

        ref_conv(1'b1, 16'h8000, en, eb);
        @(negedge clk100MHz);
        start  = 1'b1;
        mode   = 1'b1;
        raw_in = 16'h8000;
        first  = -1;
        second = -1;
        for (int t = 1; t <= 100; t++) begin
            @(posedge clk100MHz);
            #1;
            if (done) begin
                if (first < 0) begin
                    first = t;
                end else begin
                    second = t;
                    break;
                end
            end
        end
        start = 1'b0;
        check("b2b_gap", second - first, 31);
        check("b2b_bcd", {15'd0, neg, bcd}, {15'd0, en, eb});
        last_neg = en;
        last_bcd = eb;
        repeat (2) @(posedge clk100MHz);
        #1;
        check("b2b_idle", 32'(busy), 32'd0);

        @(negedge clk100MHz);
        start  = 1'b1;
        mode   = 1'b0;
        raw_in = 16'h1234;
        @(posedge clk100MHz);
        #1;
        start = 1'b0;
        repeat (9) @(posedge clk100MHz);
        #1;
        rst = 1'b1;
        @(posedge clk100MHz);
        #1;
        rst = 1'b0;
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        check("mid_rst_neg", 32'(neg), 32'd0);
        check("mid_rst_bcd", 32'(bcd), 32'd0);
        ndone = 0;
        for (int t = 0; t < 40; t++) begin
            @(posedge clk100MHz);
            #1;
            if (done)
                ndone++;
        end
        check("mid_rst_nodone", ndone, 0);
        last_neg = 1'b0;
        last_bcd = 16'h0000;
        run(1'b0, 16'h0000, 0, "post_rst");

        for (int i = 0; i < 24; i++) begin
            int g;
            g = ($urandom_range(0, 1) == 1) ? int'($urandom_range(2, 25)) : 0;
            run(1'($urandom), 16'($urandom), g, "rnd");
        end
        run(1'b0, 16'h44A1, 0, "t_zero_area");
        run(1'b1, 16'h0C4A, 0, "h_zero_area");

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
